// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane receive link trainer: finds the COM training run on both lanes, measures
// inter-lane skew at the first data byte, and delays the earlier lane so bytes pair up.
module phy_rx_lane_ctrl #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter int         TS_COUNT   = 4,
    parameter int         MAX_SKEW   = 3,
    parameter int         LOSS_LIMIT = 8
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic       valid_out,
    output logic       link_up,
    output logic [1:0] state,
    output logic [1:0] skew,
    output logic       skew_lane,
    output logic [3:0] err_count
);

    localparam int CW = $clog2(TS_COUNT + 1);
    localparam int SW = $clog2(MAX_SKEW + 2);
    localparam int LW = $clog2(LOSS_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_DETECT = 2'd1,
        ST_ALIGN  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  com_cnt_0, com_cnt_1, com_cnt_0_d, com_cnt_1_d;
    logic           seen_0, seen_1, seen_0_d, seen_1_d;
    logic [SW-1:0]  skew_cnt, skew_cnt_d;
    logic [LW-1:0]  loss_cnt_0, loss_cnt_1, loss_cnt_0_d, loss_cnt_1_d;
    logic [1:0]     skew_d;
    logic           skew_lane_d;
    logic           err_inc;
    logic           flush;
    logic           trans_0, trans_1;

    logic [MAX_SKEW-1:0][7:0] dly_data_0, dly_data_1;
    logic [MAX_SKEW-1:0]      dly_valid_0, dly_valid_1;
    logic [MAX_SKEW:0][7:0]   tap_data_0, tap_data_1;
    logic [MAX_SKEW:0]        tap_valid_0, tap_valid_1;
    logic [1:0]               sel_0, sel_1;
    logic                     out_valid_d;

    function automatic logic [CW-1:0] com_next(input logic [CW-1:0] cnt, input logic v,
                                               input logic [7:0] d);
        if (!v)
            return cnt;
        if (d != COM_SYM)
            return '0;
        return (cnt == CW'(TS_COUNT)) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [LW-1:0] loss_next(input logic [LW-1:0] cnt, input logic v);
        if (v)
            return '0;
        return (cnt == LW'(LOSS_LIMIT)) ? cnt : cnt + 1'b1;
    endfunction

    // Tap 0 is the live input; tap k is the byte seen k cycles ago.
    assign tap_data_0  = {dly_data_0, data_in_0};
    assign tap_data_1  = {dly_data_1, data_in_1};
    assign tap_valid_0 = {dly_valid_0, valid_in_0};
    assign tap_valid_1 = {dly_valid_1, valid_in_1};

    assign trans_0 = valid_in_0 && (data_in_0 != COM_SYM);
    assign trans_1 = valid_in_1 && (data_in_1 != COM_SYM);

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            com_cnt_0  <= '0;
            com_cnt_1  <= '0;
            seen_0     <= 1'b0;
            seen_1     <= 1'b0;
            skew_cnt   <= '0;
            loss_cnt_0 <= '0;
            loss_cnt_1 <= '0;
            skew       <= 2'd0;
            skew_lane  <= 1'b0;
            err_count  <= 4'd0;
        end else begin
            state_q    <= state_d;
            com_cnt_0  <= com_cnt_0_d;
            com_cnt_1  <= com_cnt_1_d;
            seen_0     <= seen_0_d;
            seen_1     <= seen_1_d;
            skew_cnt   <= skew_cnt_d;
            loss_cnt_0 <= loss_cnt_0_d;
            loss_cnt_1 <= loss_cnt_1_d;
            skew       <= skew_d;
            skew_lane  <= skew_lane_d;
            if (err_inc && (err_count != 4'hF))
                err_count <= err_count + 4'd1;
        end
    end

    // skew_cnt holds the distance in cycles since the first lane transitioned.
    always_comb begin
        state_d      = state_q;
        com_cnt_0_d  = '0;
        com_cnt_1_d  = '0;
        seen_0_d     = 1'b0;
        seen_1_d     = 1'b0;
        skew_cnt_d   = '0;
        loss_cnt_0_d = '0;
        loss_cnt_1_d = '0;
        skew_d       = skew;
        skew_lane_d  = skew_lane;
        err_inc      = 1'b0;
        flush        = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_DETECT;
            end
            ST_DETECT: begin
                com_cnt_0_d = com_next(com_cnt_0, valid_in_0, data_in_0);
                com_cnt_1_d = com_next(com_cnt_1, valid_in_1, data_in_1);
                if ((com_cnt_0_d >= CW'(TS_COUNT)) && (com_cnt_1_d >= CW'(TS_COUNT))) begin
                    state_d     = ST_ALIGN;
                    com_cnt_0_d = '0;
                    com_cnt_1_d = '0;
                end
            end
            ST_ALIGN: begin
                seen_0_d   = seen_0;
                seen_1_d   = seen_1;
                skew_cnt_d = skew_cnt;
                if (!seen_0 && !seen_1) begin
                    if (trans_0 && trans_1) begin
                        skew_d      = 2'd0;
                        skew_lane_d = 1'b0;
                        state_d     = ST_ACTIVE;
                    end else if (trans_0 || trans_1) begin
                        seen_0_d    = trans_0;
                        seen_1_d    = trans_1;
                        skew_lane_d = trans_1;
                        skew_cnt_d  = SW'(1);
                    end
                end else if (skew_cnt > SW'(MAX_SKEW)) begin
                    state_d = ST_DETECT;
                    err_inc = 1'b1;
                end else if (seen_0 ? trans_1 : trans_0) begin
                    skew_d  = skew_cnt[1:0];
                    state_d = ST_ACTIVE;
                end else begin
                    skew_cnt_d = skew_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                loss_cnt_0_d = loss_next(loss_cnt_0, valid_in_0);
                loss_cnt_1_d = loss_next(loss_cnt_1, valid_in_1);
                if ((loss_cnt_0_d >= LW'(LOSS_LIMIT)) || (loss_cnt_1_d >= LW'(LOSS_LIMIT))) begin
                    state_d      = ST_DETECT;
                    err_inc      = 1'b1;
                    flush        = 1'b1;
                    loss_cnt_0_d = '0;
                    loss_cnt_1_d = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Tap selection uses next-cycle skew so the first aligned pair leaves on the entry edge.
    always_comb begin
        sel_0       = (skew_lane_d == 1'b0) ? skew_d : 2'd0;
        sel_1       = (skew_lane_d == 1'b1) ? skew_d : 2'd0;
        out_valid_d = (state_d == ST_ACTIVE) && tap_valid_0[sel_0] && tap_valid_1[sel_1];
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            dly_data_0  <= '0;
            dly_data_1  <= '0;
            dly_valid_0 <= '0;
            dly_valid_1 <= '0;
            data_out_0  <= 8'd0;
            data_out_1  <= 8'd0;
            valid_out   <= 1'b0;
        end else begin
            dly_data_0  <= tap_data_0[MAX_SKEW-1:0];
            dly_data_1  <= tap_data_1[MAX_SKEW-1:0];
            dly_valid_0 <= flush ? '0 : tap_valid_0[MAX_SKEW-1:0];
            dly_valid_1 <= flush ? '0 : tap_valid_1[MAX_SKEW-1:0];
            valid_out   <= out_valid_d;
            if (out_valid_d) begin
                data_out_0 <= tap_data_0[sel_0];
                data_out_1 <= tap_data_1[sel_1];
            end
        end
    end

    assign state   = state_q;
    assign link_up = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Randomized bench for phy_rx_lane_ctrl: training, skew alignment, link loss and
// error saturation, checked against expectations derived from the lane-training rules.
module tb_phy_rx_lane_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam int TS = 4;
    localparam int MAXSK = 3;
    localparam int LOSS = 8;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_in_0, data_in_1;
    logic       valid_in_0, valid_in_1;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out, link_up, skew_lane;
    logic [1:0] state, skew;
    logic [3:0] err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_err = 0;

    phy_rx_lane_ctrl dut (
        .clk_4f(clk_4f), .reset(reset),
        .data_in_0(data_in_0), .valid_in_0(valid_in_0),
        .data_in_1(data_in_1), .valid_in_1(valid_in_1),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .valid_out(valid_out), .link_up(link_up), .state(state),
        .skew(skew), .skew_lane(skew_lane), .err_count(err_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of lane inputs and sample results just after the edge.
    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1);
        valid_in_0 = v0;
        data_in_0  = d0;
        valid_in_1 = v1;
        data_in_1  = d1;
        @(posedge clk_4f);
        #1;
    endtask

    function automatic logic [7:0] rand_non_com();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        if (r == COM) r = 8'h3C;
        return r;
    endfunction

    function automatic logic [7:0] rand_any();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic int err_bump(input int e);
        return (e < 15) ? e + 1 : 15;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checkOutput("reset state", state, 0);
        checkOutput("reset link_up", link_up, 0);
        checkOutput("reset valid_out", valid_out, 0);
        checkOutput("reset data_out", {data_out_1, data_out_0}, 0);
        checkOutput("reset skew", {skew_lane, skew}, 0);
        checkOutput("reset err_count", err_count, 0);
        exp_err = 0;
        @(negedge clk_4f);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("state after reset release", state, 1);
    endtask

    // A lane's training run is the number of valid COM bytes since its last valid non-COM byte.
    task automatic detect_step(input logic v0, input logic [7:0] d0, input logic v1,
                               input logic [7:0] d1, inout int run0, inout int run1,
                               output bit entered);
        applyStimulus(v0, d0, v1, d1);
        if (v0) run0 = (d0 == COM) ? run0 + 1 : 0;
        if (v1) run1 = (d1 == COM) ? run1 + 1 : 0;
        entered = (run0 >= TS) && (run1 >= TS);
        checkOutput("detect state", state, entered ? 2 : 1);
    endtask

    task automatic train_random();
        int run0 = 0, run1 = 0;
        bit entered = 0;
        logic v0, v1;
        logic [7:0] d0, d1;
        detect_step(1'b1, 8'h00, 1'b1, 8'h00, run0, run1, entered);
        for (int n = 0; n < 60 && !entered; n++) begin
            if (n < 30) begin
                v0 = ($urandom_range(0, 9) != 0);
                v1 = ($urandom_range(0, 9) != 0);
                d0 = ($urandom_range(0, 6) == 0) ? rand_non_com() : COM;
                d1 = ($urandom_range(0, 6) == 0) ? rand_non_com() : COM;
            end else begin
                v0 = 1'b1; v1 = 1'b1; d0 = COM; d1 = COM;
            end
            detect_step(v0, d0, v1, d1, run0, run1, entered);
        end
        checkOutput("training reached ALIGN", state, 2);
    endtask

    task automatic train_directed();
        logic [7:0] seq1 [7];
        int run0 = 0, run1 = 0;
        bit entered = 0;
        seq1 = '{COM, COM, 8'h55, COM, COM, COM, COM};
        detect_step(1'b1, 8'h00, 1'b1, 8'h00, run0, run1, entered);
        for (int i = 0; i < 7; i++)
            detect_step(1'b1, COM, 1'b1, seq1[i], run0, run1, entered);
    endtask

    // Early lane starts data at cycle 0, the late lane sends COM for lag cycles first.
    task automatic align_lanes(input int lag, input bit late_lane, input int n, output bit ok);
        logic [7:0] e [8];
        logic [7:0] l [8];
        logic [7:0] eb, lb, exp0, exp1;
        int i;
        e[0] = rand_non_com();
        l[0] = rand_non_com();
        for (int k = 1; k < 8; k++) begin
            e[k] = rand_any();
            l[k] = rand_any();
        end
        ok = (lag <= MAXSK);
        for (int c = 0; c < lag + n; c++) begin
            eb = (c < n) ? e[c] : rand_any();
            lb = (c < lag) ? COM : l[c - lag];
            if (late_lane) applyStimulus(1'b1, eb, 1'b1, lb);
            else           applyStimulus(1'b1, lb, 1'b1, eb);
            if (!ok) begin
                checkOutput("misaligned valid_out", valid_out, 0);
                if (c < MAXSK + 1) begin
                    checkOutput("align wait state", state, 2);
                end else begin
                    exp_err = err_bump(exp_err);
                    checkOutput("skew overflow state", state, 1);
                    checkOutput("skew overflow err_count", err_count, exp_err);
                    break;
                end
            end else if (c < lag) begin
                checkOutput("align wait state", state, 2);
                checkOutput("align wait valid_out", valid_out, 0);
            end else begin
                i = c - lag;
                exp0 = late_lane ? e[i] : l[i];
                exp1 = late_lane ? l[i] : e[i];
                checkOutput("active state", state, 3);
                checkOutput("active link_up", link_up, 1);
                checkOutput("aligned valid_out", valid_out, 1);
                checkOutput("aligned data_out_0", data_out_0, exp0);
                checkOutput("aligned data_out_1", data_out_1, exp1);
                checkOutput("measured skew", skew, lag);
                checkOutput("skew_lane", skew_lane, (lag == 0) ? 0 : (late_lane ? 0 : 1));
            end
        end
    endtask

    // which: 0 = lane 0 silent, 1 = lane 1 silent, 2 = both silent.
    task automatic loss_test(input int len, input int which);
        logic v0, v1;
        v0 = !(which == 0 || which == 2);
        v1 = !(which == 1 || which == 2);
        for (int i = 1; i <= len; i++) begin
            applyStimulus(v0, rand_any(), v1, rand_any());
            if (i >= LOSS) begin
                exp_err = err_bump(exp_err);
                checkOutput("loss state", state, 1);
                checkOutput("loss link_up", link_up, 0);
                checkOutput("loss valid_out", valid_out, 0);
                checkOutput("loss err_count", err_count, exp_err);
                return;
            end
            checkOutput("short gap state", state, 3);
            checkOutput("short gap link_up", link_up, 1);
        end
        for (int i = 0; i <= MAXSK; i++)
            applyStimulus(1'b1, rand_any(), 1'b1, rand_any());
        checkOutput("recovered state", state, 3);
        checkOutput("recovered valid_out", valid_out, 1);
        checkOutput("recovered err_count", err_count, exp_err);
    endtask

    initial begin
        bit ok;
        int lag;
        reset      = 1'b1;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        data_in_0  = 8'h00;
        data_in_1  = 8'h00;
        #12;
        do_reset();

        // Directed: aligned lanes, interrupted training, lags 2/3/4, gap of 7 then 8.
        train_random();
        align_lanes(0, 1'b1, 4, ok);
        loss_test(LOSS, 2);
        train_directed();
        align_lanes(2, 1'b1, 4, ok);
        loss_test(LOSS - 1, 1);
        loss_test(LOSS, 1);
        train_random();
        align_lanes(3, 1'b0, 5, ok);
        loss_test(LOSS, 0);
        train_random();
        align_lanes(4, 1'b1, 4, ok);

        for (int it = 0; it < 30; it++) begin
            train_random();
            lag = $urandom_range(0, 5);
            align_lanes(lag, 1'($urandom_range(0, 1)), $urandom_range(4, 6), ok);
            if (ok) begin
                if ($urandom_range(0, 1) == 1)
                    loss_test($urandom_range(1, LOSS - 1), $urandom_range(0, 2));
                loss_test(LOSS, $urandom_range(0, 2));
            end
        end

        for (int it = 0; it < 16; it++) begin
            train_random();
            align_lanes(MAXSK + 1, 1'($urandom_range(0, 1)), 4, ok);
        end
        checkOutput("saturated err_count", err_count, 15);

        train_random();
        align_lanes(1, 1'b0, 4, ok);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/phy_rx_lane_ctrl.md
Name: phy_rx_lane_ctrl

Overview:
Link-training and lane-deskew controller for the two-lane PHY receive path. It sits between the per-lane serial-to-parallel converters (8-bit byte plus valid per lane, clk_4f domain) and the 8b-to-32b demuxes. It detects the COM training pattern on both lanes, measures inter-lane skew, delays the earlier lane to align the two, then gates aligned data downstream until link loss.

Parameters:
COM_SYM, 8'hBC, training/comma symbol
TS_COUNT, 4, consecutive valid COM bytes needed per lane to leave DETECT
MAX_SKEW, 3, maximum correctable skew in clk_4f cycles; delay line depth
LOSS_LIMIT, 8, consecutive invalid cycles on either lane that drop the link

Ports:
clk_4f  in  1  byte clock; all logic on its rising edge
reset  in  1  asynchronous, active-high
data_in_0  in  8  lane 0 byte
valid_in_0  in  1  lane 0 byte valid
data_in_1  in  8  lane 1 byte
valid_in_1  in  1  lane 1 byte valid
data_out_0  out  8  aligned lane 0 byte
data_out_1  out  8  aligned lane 1 byte
valid_out  out  1  both aligned bytes valid; high only in ACTIVE
link_up  out  1  high in ACTIVE
state  out  2  0=RESET 1=DETECT 2=ALIGN 3=ACTIVE
skew  out  2  measured skew magnitude, held while ACTIVE
skew_lane  out  1  lane that was delayed (the earlier lane)
err_count  out  4  link-failure count, saturates at 15

Behaviour:
- Reset (async): state=RESET; all outputs 0; COM counters, delay lines, loss counters and skew cleared. err_count clears only on reset.
- RESET -> DETECT unconditionally on the first clock edge after reset deasserts.
- DETECT: per-lane saturating counter. A valid COM byte increments it. A valid non-COM byte clears it. An invalid cycle holds it. When both counters are >= TS_COUNT in the same cycle, go to ALIGN and clear the counters.
- ALIGN: per lane, detect the first valid non-COM byte ("transition").
  - First lane to transition: record it as skew_lane and start the skew counter at 0. The counter increments each cycle until the other lane transitions.
  - Both transitions in the same cycle: skew=0, skew_lane=0.
  - Counter exceeds MAX_SKEW before the second transition: go to DETECT, err_count++.
  - Second transition seen: latch skew and go to ACTIVE.
- Delay lines: a MAX_SKEW-deep shift register per lane (data plus valid), shifting every cycle in every state. In ACTIVE, the skew_lane lane is read at tap=skew and the other lane at tap 0 (tap 0 = current input).
- Outputs are registered, so latency is 1 cycle plus the tap delay.
- The first data byte of each lane appears together on data_out_0/1 with valid_out=1, one cycle after the later lane's first data byte is sampled.
- valid_out = delayed valid_0 AND delayed valid_1. When valid_out=0, data_out holds its previous value.
- ACTIVE loss detection: a per-lane counter of consecutive cycles with valid_in=0. If either counter reaches LOSS_LIMIT, go to DETECT and err_count++. In the same cycle, valid_out and link_up drop and the delay lines flush to invalid.
- A valid COM byte in ACTIVE is ordinary data and is not stripped.
- err_count saturates at 15, with no wrap.
- Reset asserted mid-operation in any state behaves exactly as the initial reset.

Test Plan:
- Reset then 4 COM bytes on both lanes, aligned, then 8'h11/8'h22 -> state 1->2->3; skew=0; data_out_0=8'h11 and data_out_1=8'h22 with valid_out=1 one cycle after the data sample.
- Lane 1 lags lane 0 by 2 cycles; lane 0 data 8'hA0,A1,A2, lane 1 data 8'hB0,B1,B2 -> skew=2, skew_lane=0; output pairs (A0,B0), (A1,B1), (A2,B2) on consecutive cycles.
- Lane 0 lags by 3 (MAX_SKEW) -> skew=3, skew_lane=1, aligned. Lag of 4 -> return to DETECT, err_count=1, valid_out never high.
- In DETECT, lane 1 sends COM,COM,8'h55,COM x4 -> ALIGN entered only after the fourth COM following 8'h55.
- In ACTIVE, valid_in_1 low for 8 cycles -> state=1 on the 8th cycle, link_up=0, err_count increments. Low for 7 cycles then high -> link stays up.
- Force 16 link failures -> err_count stays at 15. Assert reset mid-ACTIVE -> all outputs 0 asynchronously.
